// File: rtl/div_hilo_sequencer.sv
// div_hilo_sequencer: owns architectural HI/LO for the MIPS core, accepts
// DIV/DIVU/MTHI/MTLO/MFHI/MFLO from EX and sequences the iterative divider.
//
// Handshake: an op transfers on the rising edge where req_valid && req_ready.
// req_ready is combinational: high only in IDLE and only when flush is low.
// The requester must hold req_op/req_a/req_b stable while req_valid is high
// and req_ready is low.
//
// A flush during a divide cannot abort the engine. It only marks the divide
// as killed, so the engine result is dropped when it arrives.
module div_hilo_sequencer #(
  parameter int unsigned RES_LAT     = 1,   // busy-fall to result-valid cycles (>= 1)
  parameter int unsigned TIMEOUT_CYC = 48   // WAIT cycles before timeout_err
) (
  input  logic        Clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  input  logic        flush,
  output logic        mf_valid,
  output logic [31:0] mf_data,
  output logic        div_start,
  output logic        div_sign,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_busy,
  input  logic [63:0] div_result,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        timeout_err
);

  localparam logic [2:0] OP_DIV  = 3'd0;
  localparam logic [2:0] OP_DIVU = 3'd1;
  localparam logic [2:0] OP_MTHI = 3'd2;
  localparam logic [2:0] OP_MTLO = 3'd3;
  localparam logic [2:0] OP_MFHI = 3'd4;
  localparam logic [2:0] OP_MFLO = 3'd5;

  localparam int unsigned WCW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned SCW = $clog2(RES_LAT + 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_SETTLE = 3'd3,
    S_WRITE  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             mf_valid_q, mf_valid_d;
  logic [31:0]      mf_data_q, mf_data_d;
  logic             div_sign_q, div_sign_d;
  logic [31:0]      div_a_q, div_a_d;
  logic [31:0]      div_b_q, div_b_d;
  logic             kill_q, kill_d;
  logic             timeout_q, timeout_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [SCW-1:0]   settle_cnt_q, settle_cnt_d;
  logic             accept;

  assign req_ready   = (state_q == S_IDLE) && !flush;
  assign accept      = req_valid && req_ready;
  assign busy        = (state_q != S_IDLE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign mf_valid    = mf_valid_q;
  assign mf_data     = mf_data_q;
  assign div_sign    = div_sign_q;
  assign div_a       = div_a_q;
  assign div_b       = div_b_q;
  assign timeout_err = timeout_q;

  // Next-state, HI/LO updates and the launch pulse for the sequencer FSM.
  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    mf_valid_d   = 1'b0;
    mf_data_d    = mf_data_q;
    div_sign_d   = div_sign_q;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    kill_d       = kill_q;
    timeout_d    = timeout_q;
    wait_cnt_d   = wait_cnt_q;
    settle_cnt_d = settle_cnt_q;
    div_start    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (req_op)
            OP_DIV, OP_DIVU: begin
              div_a_d    = req_a;
              div_b_d    = req_b;
              div_sign_d = (req_op == OP_DIV);
              state_d    = S_LAUNCH;
            end
            OP_MTHI: hi_d = req_a;
            OP_MTLO: lo_d = req_a;
            OP_MFHI: begin
              mf_valid_d = 1'b1;
              mf_data_d  = hi_q;
            end
            OP_MFLO: begin
              mf_valid_d = 1'b1;
              mf_data_d  = lo_q;
            end
            default: ; // reserved ops are swallowed with no effect
          endcase
        end
      end

      S_LAUNCH: begin
        div_start  = 1'b1;
        wait_cnt_d = '0;
        kill_d     = kill_q | flush;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        kill_d = kill_q | flush;
        if (!div_busy) begin
          settle_cnt_d = SCW'(RES_LAT);
          state_d      = S_SETTLE;
        end else if (wait_cnt_q == WCW'(TIMEOUT_CYC - 1)) begin
          // Engine never finished: give up, drop the result.
          timeout_d = 1'b1;
          kill_d    = 1'b0;
          state_d   = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end

      S_SETTLE: begin
        kill_d = kill_q | flush;
        if (settle_cnt_q <= SCW'(1)) begin
          state_d = S_WRITE;
        end else begin
          settle_cnt_d = settle_cnt_q - SCW'(1);
        end
      end

      S_WRITE: begin
        // A flush arriving in this very cycle still discards the result.
        if (!(kill_q || flush)) begin
          hi_d = div_result[63:32];
          lo_d = div_result[31:0];
        end
        kill_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and architectural registers; reset abandons any divide in flight.
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      hi_q         <= '0;
      lo_q         <= '0;
      mf_valid_q   <= 1'b0;
      mf_data_q    <= '0;
      div_sign_q   <= 1'b0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      kill_q       <= 1'b0;
      timeout_q    <= 1'b0;
      wait_cnt_q   <= '0;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      mf_valid_q   <= mf_valid_d;
      mf_data_q    <= mf_data_d;
      div_sign_q   <= div_sign_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      kill_q       <= kill_d;
      timeout_q    <= timeout_d;
      wait_cnt_q   <= wait_cnt_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

endmodule
